// File: rtl/pwm_measure_multi_if.sv
// rtl/pwm_measure_multi_if.sv - pulse inputs and per-channel result bundle for pwm_measure_multi
interface pwm_measure_multi_if #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 16
);
    logic [NUM_CH-1:0]       pwm_in;
    logic [NUM_CH-1:0]       mode;
    logic [NUM_CH*CNT_W-1:0] width;
    logic [NUM_CH-1:0]       valid;
    logic [NUM_CH-1:0]       timeout;

    modport master (
        output pwm_in, mode,
        input  width, valid, timeout
    );

    modport slave (
        input  pwm_in, mode,
        output width, valid, timeout
    );
endinterface

// File: rtl/pwm_measure_multi.sv
// rtl/pwm_measure_multi.sv - multi-channel pulse width / period measurer with timeout
module pwm_measure_multi #(
    parameter int NUM_CH        = 2,
    parameter int CNT_W         = 16,
    parameter int PRESCALE      = 100,
    parameter int TIMEOUT_TICKS = 38000,
    parameter int SYNC_STAGES   = 2
) (
    input  logic               clk,
    input  logic               reset,
    pwm_measure_multi_if.slave bus
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SW = $clog2(SYNC_STAGES + 1);

    localparam logic [1:0] WAIT_LOW = 2'd0;
    localparam logic [1:0] IDLE     = 2'd1;
    localparam logic [1:0] MEAS     = 2'd2;

    logic [PW-1:0]          pre_cnt;
    logic                   tick;
    logic [SW-1:0]          prime_cnt;
    logic                   primed;
    logic [SYNC_STAGES-1:0] sync_r [NUM_CH];
    logic [NUM_CH-1:0]      in_s;
    logic [NUM_CH-1:0]      in_q;
    logic [NUM_CH-1:0]      rise;
    logic [NUM_CH-1:0]      fall;
    logic [NUM_CH-1:0]      mode_q;
    logic [1:0]             state  [NUM_CH];
    logic [CNT_W-1:0]       count  [NUM_CH];
    logic [CNT_W-1:0]       v      [NUM_CH];

    // With PRESCALE=1 the counter never leaves 0, so tick is permanently high.
    assign tick = (pre_cnt == PW'(PRESCALE - 1));

    // The last sync stage only reflects post-reset input once the chain has refilled;
    // until then WAIT_LOW must not trust a reset-value zero as a real low level.
    assign primed = (prime_cnt == SW'(SYNC_STAGES));

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            in_s[c] = sync_r[c][SYNC_STAGES-1];
            rise[c] = in_s[c] & ~in_q[c];
            fall[c] = ~in_s[c] & in_q[c];
            v[c]    = count[c] + CNT_W'(tick);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_cnt     <= '0;
            prime_cnt   <= '0;
            in_q        <= '0;
            mode_q      <= '0;
            bus.width   <= '0;
            bus.valid   <= '0;
            bus.timeout <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                sync_r[c] <= '0;
                state[c]  <= WAIT_LOW;
                count[c]  <= '0;
            end
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
            if (!primed)
                prime_cnt <= prime_cnt + SW'(1);
            bus.valid <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                sync_r[c] <= {sync_r[c][SYNC_STAGES-2:0], bus.pwm_in[c]};
                in_q[c]   <= in_s[c];
                case (state[c])
                    WAIT_LOW: begin
                        if (primed && !in_s[c])
                            state[c] <= IDLE;
                    end
                    IDLE: begin
                        if (rise[c]) begin
                            state[c]  <= MEAS;
                            count[c]  <= '0;
                            mode_q[c] <= bus.mode[c];
                        end
                    end
                    MEAS: begin
                        // An end edge takes priority over the timeout landing in the same cycle.
                        if (bus.mode[c] != mode_q[c]) begin
                            state[c] <= WAIT_LOW;
                        end else if (!mode_q[c] && fall[c]) begin
                            bus.width[c*CNT_W +: CNT_W] <= v[c];
                            bus.valid[c]   <= 1'b1;
                            bus.timeout[c] <= 1'b0;
                            state[c]       <= IDLE;
                        end else if (mode_q[c] && rise[c]) begin
                            bus.width[c*CNT_W +: CNT_W] <= v[c];
                            bus.valid[c]   <= 1'b1;
                            bus.timeout[c] <= 1'b0;
                            count[c]       <= '0;
                        end else if (v[c] == CNT_W'(TIMEOUT_TICKS)) begin
                            bus.width[c*CNT_W +: CNT_W] <= CNT_W'(TIMEOUT_TICKS);
                            bus.valid[c]   <= 1'b1;
                            bus.timeout[c] <= 1'b1;
                            state[c]       <= WAIT_LOW;
                        end else begin
                            count[c] <= v[c];
                        end
                    end
                    default: state[c] <= WAIT_LOW;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pwm_measure_multi.sv
// tb/tb_pwm_measure_multi.sv - scoreboard bench for pwm_measure_multi (PRESCALE 1 and 10)
module tb_pwm_measure_multi;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        int ch;
        int w;
        bit to;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;
    int vcnt_a[2];
    int vcnt_b[2];
    int vcyc_a[2];
    int vcyc_b[2];

    pwm_measure_multi_if #(.NUM_CH(2), .CNT_W(16)) ifa ();
    pwm_measure_multi_if #(.NUM_CH(2), .CNT_W(16)) ifb ();

    pwm_measure_multi #(
        .NUM_CH(2), .CNT_W(16), .PRESCALE(1), .TIMEOUT_TICKS(100), .SYNC_STAGES(2)
    ) dut_a (
        .clk(clk), .reset(reset), .bus(ifa)
    );

    pwm_measure_multi #(
        .NUM_CH(2), .CNT_W(16), .PRESCALE(10), .TIMEOUT_TICKS(100), .SYNC_STAGES(2)
    ) dut_b (
        .clk(clk), .reset(reset), .bus(ifb)
    );

    always @(negedge clk) begin
        if (reset) begin
            for (int c = 0; c < 2; c++) begin
                if (ifa.valid[c] === 1'b1) begin
                    vcnt_a[c]++;
                    vcyc_a[c] = cyc;
                    tests_run++;
                    if (qa.size() == 0) begin
                        tests_failed++;
                        $display("FAIL a_unexpected_valid ch%0d: got width %0d, required no valid", c, ifa.width[c*16 +: 16]);
                    end else begin
                        ea = qa.pop_front();
                        if (ea.ch != c || ifa.width[c*16 +: 16] !== 16'(ea.w) || ifa.timeout[c] !== ea.to) begin
                            tests_failed++;
                            $display("FAIL a_result ch%0d: got width %0d timeout %0b, required ch%0d width %0d timeout %0b",
                                     c, ifa.width[c*16 +: 16], ifa.timeout[c], ea.ch, ea.w, ea.to);
                        end
                    end
                end
                if (ifb.valid[c] === 1'b1) begin
                    vcnt_b[c]++;
                    vcyc_b[c] = cyc;
                    tests_run++;
                    if (qb.size() == 0) begin
                        tests_failed++;
                        $display("FAIL b_unexpected_valid ch%0d: got width %0d, required no valid", c, ifb.width[c*16 +: 16]);
                    end else begin
                        eb = qb.pop_front();
                        if (eb.ch != c || ifb.width[c*16 +: 16] !== 16'(eb.w) || ifb.timeout[c] !== eb.to) begin
                            tests_failed++;
                            $display("FAIL b_result ch%0d: got width %0d timeout %0b, required ch%0d width %0d timeout %0b",
                                     c, ifb.width[c*16 +: 16], ifb.timeout[c], eb.ch, eb.w, eb.to);
                        end
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_a(input int ch, input int w, input bit to);
        exp_t e;
        e.ch = ch; e.w = w; e.to = to;
        qa.push_back(e);
    endtask

    task automatic push_b(input int ch, input int w, input bit to);
        exp_t e;
        e.ch = ch; e.w = w; e.to = to;
        qb.push_back(e);
    endtask

    task automatic pulse_a(input int ch, input int n);
        ifa.pwm_in[ch] = 1'b1;
        step(n);
        ifa.pwm_in[ch] = 1'b0;
    endtask

    task automatic check_int(input string name, input int got, input int req);
        tests_run++;
        if (got !== req) begin
            tests_failed++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        ifa.pwm_in = '0; ifa.mode = '0;
        ifb.pwm_in = '0; ifb.mode = '0;
        step(3);
        check_int("reset_a_width", int'(ifa.width), 0);
        check_int("reset_a_valid", int'(ifa.valid), 0);
        check_int("reset_a_timeout", int'(ifa.timeout), 0);
        check_int("reset_b_width", int'(ifb.width), 0);
        check_int("reset_b_valid", int'(ifb.valid), 0);
        check_int("reset_b_timeout", int'(ifb.timeout), 0);
        reset = 1'b1;
        step(5);
    endtask

    task automatic test_width();
        int base;
        int fall_cyc;
        base = vcnt_a[0];
        push_a(0, 20, 1'b0);
        pulse_a(0, 20);
        fall_cyc = cyc;
        step(10);
        check_int("width_single_valid", vcnt_a[0] - base, 1);
        check_int("width_latency", vcyc_a[0] - fall_cyc, 3);
        check_int("width_ch1_quiet", vcnt_a[1], 0);
        check_int("width_queue_empty", qa.size(), 0);
    endtask

    task automatic test_timeout();
        int base;
        base = vcnt_a[0];
        push_a(0, 100, 1'b1);
        pulse_a(0, 150);
        step(10);
        check_int("timeout_single_valid", vcnt_a[0] - base, 1);
        check_int("timeout_flag_held", int'(ifa.timeout[0]), 1);
        check_int("timeout_width_held", int'(ifa.width[15:0]), 100);
        push_a(0, 30, 1'b0);
        pulse_a(0, 30);
        step(10);
        check_int("timeout_cleared", int'(ifa.timeout[0]), 0);
        check_int("timeout_next_count", vcnt_a[0] - base, 2);
        check_int("timeout_queue_empty", qa.size(), 0);
    endtask

    task automatic test_period();
        int base0;
        base0 = vcnt_a[0];
        ifa.mode[1] = 1'b1;
        step(2);
        for (int i = 0; i < 4; i++) push_a(1, 25, 1'b0);
        for (int i = 0; i < 5; i++) begin
            ifa.pwm_in[1] = 1'b1;
            step(10);
            ifa.pwm_in[1] = 1'b0;
            step(15);
        end
        // Flipping mode mid-measurement must abort silently instead of timing out.
        ifa.mode[1] = 1'b0;
        step(150);
        check_int("period_valid_count", vcnt_a[1], 4);
        check_int("period_ch0_quiet", vcnt_a[0] - base0, 0);
        check_int("period_queue_empty", qa.size(), 0);
    endtask

    task automatic test_high_at_release();
        int base;
        ifa.pwm_in[0] = 1'b1;
        reset = 1'b0;
        step(3);
        reset = 1'b1;
        base = vcnt_a[0];
        step(40);
        ifa.pwm_in[0] = 1'b0;
        step(20);
        check_int("release_no_partial", vcnt_a[0] - base, 0);
        push_a(0, 12, 1'b0);
        pulse_a(0, 12);
        step(10);
        check_int("release_next_count", vcnt_a[0] - base, 1);
        check_int("release_queue_empty", qa.size(), 0);
    endtask

    task automatic test_reset_mid_pulse();
        int base0;
        int base1;
        base0 = vcnt_a[0];
        base1 = vcnt_a[1];
        push_a(0, 100, 1'b1);
        ifa.pwm_in[0] = 1'b1;
        step(80);
        ifa.pwm_in[1] = 1'b1;
        step(30);
        check_int("midrst_pre_result", vcnt_a[0] - base0, 1);
        check_int("midrst_pre_timeout", int'(ifa.timeout[0]), 1);
        #1 reset = 1'b0;
        #1;
        check_int("midrst_width_clear", int'(ifa.width), 0);
        check_int("midrst_valid_clear", int'(ifa.valid), 0);
        check_int("midrst_timeout_clear", int'(ifa.timeout), 0);
        @(negedge clk);
        step(2);
        reset = 1'b1;
        step(20);
        ifa.pwm_in = '0;
        step(20);
        check_int("midrst_no_valid_ch0", vcnt_a[0] - base0, 1);
        check_int("midrst_no_valid_ch1", vcnt_a[1] - base1, 0);
        check_int("midrst_queue_empty", qa.size(), 0);
    endtask

    task automatic test_prescale();
        int base;
        base = vcnt_b[0];
        for (int ph = 0; ph < 4; ph++) begin
            step(ph + 3);
            push_b(0, 10, 1'b0);
            ifb.pwm_in[0] = 1'b1;
            step(100);
            ifb.pwm_in[0] = 1'b0;
            step(10);
        end
        check_int("prescale_phase_count", vcnt_b[0] - base, 4);
        push_b(0, 10, 1'b0);
        push_b(1, 5, 1'b0);
        ifb.pwm_in[0] = 1'b1;
        step(50);
        ifb.pwm_in[1] = 1'b1;
        step(50);
        ifb.pwm_in = '0;
        step(10);
        check_int("prescale_both_same_cycle", vcyc_b[1], vcyc_b[0]);
        check_int("prescale_ch1_count", vcnt_b[1], 1);
        check_int("prescale_queue_empty", qb.size(), 0);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_width();
        test_timeout();
        test_period();
        test_high_at_release();
        test_reset_mid_pulse();
        test_prescale();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
